// File: rtl/multi_variable_stepdown.sv
// N-channel glitch-free clock divider / step-rate generator for stepper drivers.
// Define STEPDOWN_RAMP_EN to add linear acceleration from RAMP_START down to division.
module multi_variable_stepdown #(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      CHANNELS   = 2,
  parameter logic [WIDTH-1:0] RAMP_START = WIDTH'(4000),
  parameter logic [WIDTH-1:0] RAMP_STEP  = WIDTH'(8)
) (
  input  logic                      in_clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] division,
  output logic [CHANNELS-1:0]       out_clk,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_n;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] w_div_n;
    logic             r_out;
    logic             w_out_n;
    logic             r_tick;
    logic             w_tick_n;
    logic [WIDTH-1:0] w_div_in;
    logic [WIDTH-1:0] w_start;
    logic [WIDTH-1:0] w_reload;
    logic             w_term;
    logic             w_go;

    assign w_div_in = division[k*WIDTH +: WIDTH];
    assign w_term   = (r_cnt == r_div - 1'b1);
    assign w_go     = enable[k] && (w_div_in != '0);

`ifdef STEPDOWN_RAMP_EN
    assign w_start  = (w_div_in > RAMP_START) ? w_div_in : RAMP_START;
    // Speed-ups step down gradually; slow-downs apply at once.
    assign w_reload = (r_div <= w_div_in)            ? w_div_in :
                      (r_div - w_div_in > RAMP_STEP) ? r_div - RAMP_STEP :
                                                       w_div_in;
`else
    logic w_unused_ramp;
    assign w_unused_ramp = ^{RAMP_START, RAMP_STEP};
    assign w_start  = w_div_in;
    assign w_reload = w_div_in;
`endif

    always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_div_n   = r_div;
      w_out_n   = r_out;
      w_tick_n  = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          w_cnt_n = '0;
          w_out_n = 1'b0;
          if (w_go) begin
            w_state_n = S_RUN;
            w_div_n   = w_start;
          end
        end
        S_RUN, S_STOP: begin
          if (w_term) begin
            // Toggle always lands first; stop decision follows.
            w_out_n  = ~r_out;
            w_tick_n = 1'b1;
            w_cnt_n  = '0;
            if (w_go) begin
              w_state_n = S_RUN;
              w_div_n   = w_reload;
            end else if (r_out) begin
              w_state_n = S_IDLE;
            end else begin
              w_state_n = S_STOP;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
            if (r_state == S_RUN && !enable[k]) begin
              if (!r_out) begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
              end else begin
                w_state_n = S_STOP;
              end
            end else if (r_state == S_STOP && w_go) begin
              w_state_n = S_RUN;
            end
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_out_n   = 1'b0;
        end
      endcase
    end

    always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_div   <= '0;
        r_out   <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        r_state <= w_state_n;
        r_cnt   <= w_cnt_n;
        r_div   <= w_div_n;
        r_out   <= w_out_n;
        r_tick  <= w_tick_n;
      end
    end

    assign out_clk[k] = r_out;
    assign tick[k]    = r_tick;
    assign busy[k]    = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_multi_variable_stepdown.sv
// Directed bench for multi_variable_stepdown; expected out_clk edges are
// queued per channel as stimulus is applied and matched as edges appear.
module tb_multi_variable_stepdown;
  localparam int W  = 16;
  localparam int CH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   enable;
  logic [CH*W-1:0] division;
  logic [CH-1:0]   out_clk;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   busy;

  always #5 clk = ~clk;

  multi_variable_stepdown #(
    .WIDTH(W),
    .CHANNELS(CH),
    .RAMP_START(16'd40),
    .RAMP_STEP(16'd8)
  ) dut (
    .in_clk(clk),
    .reset_n(rst_n),
    .enable(enable),
    .division(division),
    .out_clk(out_clk),
    .tick(tick),
    .busy(busy)
  );

  typedef struct {
    int   c;
    logic v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [CH-1:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int c, input logic v);
    exp_t e;
    e.c = c;
    e.v = v;
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_div(input int ch, input int d);
    logic [W-1:0] v;
    v = d[W-1:0];
    division[ch*W +: W] = v;
  endtask

  // Edge monitor: every out_clk change must carry tick and match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      for (int k = 0; k < CH; k++) begin
        chk($sformatf("tick%0d", k), tick[k], out_clk[k] !== prev[k]);
        if (out_clk[k] !== prev[k]) begin
          if (k == 0) begin
            chk("edge0_queued", q0.size() != 0, 1);
            if (q0.size() != 0) begin
              e = q0.pop_front();
              chk("edge0_cyc", cyc, e.c);
              chk("edge0_val", out_clk[0], e.v);
            end
          end else begin
            chk("edge1_queued", q1.size() != 0, 1);
            if (q1.size() != 0) begin
              e = q1.pop_front();
              chk("edge1_cyc", cyc, e.c);
              chk("edge1_val", out_clk[1], e.v);
            end
          end
        end
      end
    end
    prev <= out_clk;
  end

  initial begin
    int c;
    int t;
    int hp[6];

    // Reset held with channels requested
    rst_n    = 1'b0;
    enable   = 2'b11;
    division = '0;
    set_div(0, 5);
    set_div(1, 5);
    step(3);
    chk("rst_out", out_clk, 2'b00);
    chk("rst_tick", tick, 2'b00);
    chk("rst_busy", busy, 2'b00);
    c = cyc;
    rst_n = 1'b1;
    for (int ch = 0; ch < CH; ch++) begin
      push(ch, c + 6, 1'b1);
      push(ch, c + 11, 1'b0);
      push(ch, c + 16, 1'b1);
    end
    step(18);
    chk("t1_out_high", out_clk, 2'b11);
    chk("t1_q0_empty", q0.size(), 0);
    chk("t1_q1_empty", q1.size(), 0);
    // Mid-run reset: immediate, no final edge
    rst_n = 1'b0;
    #1;
    chk("t1_mid_rst_out", out_clk, 2'b00);
    chk("t1_mid_rst_busy", busy, 2'b00);
    chk("t1_mid_rst_tick", tick, 2'b00);
    enable = 2'b00;
    step(2);
    rst_n = 1'b1;
    step(2);

    // division=3 steady run
    c = cyc;
    set_div(0, 3);
    enable = 2'b01;
    for (int k = 1; k <= 20; k++) push(0, c + 1 + 3 * k, logic'(k % 2));
    for (int i = 1; i <= 61; i++) begin
      step(1);
      chk("t2_busy", busy, 2'b01);
    end
    enable = 2'b00;
    step(1);
    chk("t2_idle", busy, 2'b00);
    chk("t2_q0_empty", q0.size(), 0);
    step(2);

    // Rate change mid high phase waits for the terminal
    c = cyc;
    set_div(0, 10);
    enable = 2'b01;
    push(0, c + 11, 1'b1);
    push(0, c + 21, 1'b0);
    push(0, c + 23, 1'b1);
    push(0, c + 25, 1'b0);
    push(0, c + 27, 1'b1);
    push(0, c + 29, 1'b0);
    step(14);
    set_div(0, 2);
    step(6);
    chk("t3_still_high", out_clk[0], 1'b1);
    step(9);
    chk("t3_low", out_clk[0], 1'b0);
    enable = 2'b00;
    step(1);
    chk("t3_idle_next", busy, 2'b00);
    chk("t3_q0_empty", q0.size(), 0);
    step(2);

    // Stop requested during a high phase finishes the phase
    c = cyc;
    set_div(0, 10);
    enable = 2'b01;
    push(0, c + 11, 1'b1);
    push(0, c + 21, 1'b0);
    step(13);
    enable = 2'b00;
    step(7);
    chk("t4_stopping_busy", busy, 2'b01);
    chk("t4_stopping_out", out_clk, 2'b01);
    step(1);
    chk("t4_done_busy", busy, 2'b00);
    chk("t4_done_out", out_clk, 2'b00);
    chk("t4_q0_empty", q0.size(), 0);
    step(2);

    // Two channels: in_clk/2 and period 14
    c = cyc;
    set_div(0, 1);
    set_div(1, 7);
    enable = 2'b11;
    for (int k = 1; k <= 40; k++) push(0, c + 1 + k, logic'(k % 2));
    push(1, c + 8, 1'b1);
    push(1, c + 15, 1'b0);
    push(1, c + 22, 1'b1);
    push(1, c + 29, 1'b0);
    step(30);
    enable = 2'b01;
    step(1);
    chk("t5_ch1_off", busy, 2'b01);
    step(9);
    chk("t5_ch0_high", out_clk[0], 1'b1);
    enable = 2'b00;
    step(1);
    chk("t5_all_idle", busy, 2'b00);
    step(1);
    chk("t5_q0_empty", q0.size(), 0);
    chk("t5_q1_empty", q1.size(), 0);
    step(2);

    // Start-up profile toward division=10
`ifdef STEPDOWN_RAMP_EN
    hp = '{40, 32, 24, 16, 10, 10};
`else
    hp = '{10, 10, 10, 10, 10, 10};
`endif
    c = cyc;
    set_div(1, 10);
    enable = 2'b10;
    t = c + 1;
    for (int i = 0; i < 6; i++) begin
      t += hp[i];
      push(1, t, logic'((i + 1) % 2));
    end
    step(t - c);
    chk("t6_low_end", out_clk[1], 1'b0);
    enable = 2'b00;
    step(1);
    chk("t6_idle", busy, 2'b00);
    step(1);
    chk("t6_q1_empty", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
